lemming_world: RTL

//  Environment model that closes the loop around the lemmings walker FSM: it drives the walker's

---
 rtl/lemming_world.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lemming_world.sv
// Environment model around the lemmings walker FSM: tracks column and depth,
// models walls, surface holes, timed digging and timed falls, and flags
// splat and multi-hot walker outputs.
module lemming_world #(
  parameter int WIDTH       = 16,
  parameter int POS_W       = 4,
  parameter int START_POS   = 8,
  parameter int LEVELS      = 4,
  parameter int LVL_W       = 2,
  parameter int FALL_CYCLES = 4,
  parameter int DIG_CYCLES  = 3
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             walk_left,
  input  logic             walk_right,
  input  logic             aaah,
  input  logic             digging,
  input  logic [WIDTH-1:0] hole_map,
  input  logic             dig_req,
  output logic             bump_left,
  output logic             bump_right,
  output logic             ground,
  output logic             dig,
  output logic [POS_W-1:0] pos,
  output logic [LVL_W-1:0] level,
  output logic             splat,
  output logic             proto_err
);

  localparam int FC_W = (FALL_CYCLES < 2) ? 1 : $clog2(FALL_CYCLES + 1);
  localparam int DC_W = (DIG_CYCLES < 2) ? 1 : $clog2(DIG_CYCLES + 1);

  typedef enum logic [1:0] {S_WALK, S_FALL, S_DIG, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [POS_W-1:0] r_pos, w_pos_next;
  logic [LVL_W-1:0] r_level, w_level_next;
  logic [FC_W-1:0]  r_fall_cnt, w_fall_cnt_next;
  logic [DC_W-1:0]  r_dig_cnt, w_dig_cnt_next;
  logic             r_dig_pending, w_dig_pending_next;
  logic             r_splat, w_splat_next;
  logic             r_proto_err, w_proto_err_next;

  logic             w_in_walk;
  logic             w_bedrock;
  logic             w_dig_clear;
  logic [2:0]       w_n_active;

  // Walker-facing combinational outputs derived from the current state.
  always_comb begin
    w_in_walk  = (r_state == S_WALK);
    w_bedrock  = (r_level == LVL_W'(LEVELS - 1));
    w_n_active = {2'b00, walk_left} + {2'b00, walk_right} + {2'b00, aaah} + {2'b00, digging};
    bump_left  = w_in_walk & walk_left  & (r_pos == '0);
    bump_right = w_in_walk & walk_right & (r_pos == POS_W'(WIDTH - 1));
    ground     = 1'b1;
    case (r_state)
      S_WALK:  ground = ~((r_level == '0) & hole_map[r_pos]);
      S_FALL:  ground = 1'b0;
      S_DIG:   ground = ~((r_dig_cnt == DC_W'(DIG_CYCLES)) & ~w_bedrock);
      default: ground = 1'b1;
    endcase
    // A hole under the walker takes precedence over issuing a dig.
    dig = r_dig_pending & w_in_walk & ground;
  end

  // Next-state, movement and sticky-flag logic.
  always_comb begin
    w_state_next    = r_state;
    w_pos_next      = r_pos;
    w_level_next    = r_level;
    w_fall_cnt_next = r_fall_cnt;
    w_dig_cnt_next  = r_dig_cnt;
    w_splat_next    = r_splat;
    w_dig_clear     = 1'b0;
    case (r_state)
      S_WALK: begin
        if (!ground) begin
          w_state_next    = S_FALL;
          w_fall_cnt_next = '0;
        end else begin
          if (walk_left && !bump_left)
            w_pos_next = r_pos - 1'b1;
          else if (walk_right && !bump_right)
            w_pos_next = r_pos + 1'b1;
          if (digging) begin
            w_state_next   = S_DIG;
            w_dig_cnt_next = '0;
            w_dig_clear    = 1'b1;
          end else if (w_n_active == 3'd0) begin
            // A walker with every output low on solid ground has died.
            w_state_next = S_DONE;
            w_splat_next = 1'b1;
          end
        end
      end
      S_DIG: begin
        if (!ground) begin
          w_state_next    = S_FALL;
          w_fall_cnt_next = '0;
        end else if (r_dig_cnt != DC_W'(DIG_CYCLES)) begin
          w_dig_cnt_next = r_dig_cnt + 1'b1;
        end
      end
      S_FALL: begin
        if (r_fall_cnt == FC_W'(FALL_CYCLES - 1)) begin
          w_state_next = S_WALK;
          if (!w_bedrock)
            w_level_next = r_level + 1'b1;
        end else begin
          w_fall_cnt_next = r_fall_cnt + 1'b1;
        end
      end
      S_DONE: w_state_next = S_DONE;
      default: w_state_next = S_WALK;
    endcase
    // Clearing on dig entry beats a same-cycle request.
    w_dig_pending_next = w_dig_clear ? 1'b0 : (r_dig_pending | dig_req);
    w_proto_err_next   = r_proto_err | (w_n_active >= 3'd2);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state       <= S_WALK;
      r_pos         <= POS_W'(START_POS);
      r_level       <= '0;
      r_fall_cnt    <= '0;
      r_dig_cnt     <= '0;
      r_dig_pending <= 1'b0;
      r_splat       <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pos         <= w_pos_next;
      r_level       <= w_level_next;
      r_fall_cnt    <= w_fall_cnt_next;
      r_dig_cnt     <= w_dig_cnt_next;
      r_dig_pending <= w_dig_pending_next;
      r_splat       <= w_splat_next;
      r_proto_err   <= w_proto_err_next;
    end
  end

  assign pos       = r_pos;
  assign level     = r_level;
  assign splat     = r_splat;
  assign proto_err = r_proto_err;

endmodule
